mem_stage: RTL and testbench

//  MEM stage of the 5-stage LoongArch pipeline: the transmitter feeding ms_to_ws_bus/ms_to_ws_valid into the

---
 rtl/mem_stage_pkg.sv | 44 ++++
 rtl/mem_ld_align.sv | 43 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM stage of the 5-stage LoongArch pipeline:
// bus widths, load-op bit indices, the load-tracking FSM state encoding and
// the packed layout of the EX->MEM bus.
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int XLEN = 32;   // datapath / pc width
    localparam int RA_W = 5;    // register-number width

    localparam int ES_TO_MS_BUS_WD = 78;
    localparam int MS_TO_WS_BUS_WD = 70;
    // {ms_valid, ms_ready_go, rf_we, dest[4:0], result[31:0]}; the width is
    // the sum of those fields.
    localparam int MS_TO_DS_BUS_WD = 3 + RA_W + XLEN;

    // ld_op one-hot bit positions, ordered {b, h, w, bu, hu}
    localparam int LD_OP_W = 5;
    localparam int LD_B    = 4;
    localparam int LD_H    = 3;
    localparam int LD_W    = 2;
    localparam int LD_BU   = 1;
    localparam int LD_HU   = 0;

    // Load-tracking FSM
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // no load outstanding
        S_WAIT = 2'd1,   // load issued, waiting for data_ok
        S_HOLD = 2'd2    // data arrived while WB stalled; held in rdata_buf
    } ms_state_e;

    // EX->MEM bus layout (78 bits)
    typedef struct packed {
        logic [LD_OP_W-1:0] ld_op;
        logic               mem_ld;
        logic               rf_we;
        logic [RA_W-1:0]    dest;
        logic [1:0]         addr_lo;
        logic [XLEN-1:0]    alu_res;
        logic [XLEN-1:0]    pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_ld_align.sv
// -----------------------------------------------------------------------------
// mem_ld_align
// Combinational load-data extractor. Picks the addressed byte / half-word out
// of the 32-bit SRAM word and sign- or zero-extends it.
// Ports:
//   rdata   in  32  raw load word (live SRAM data or buffered copy)
//   addr_lo in  2   byte offset within the word
//   ld_op   in  5   one-hot {b, h, w, bu, hu}
//   result  out 32  aligned, extended load value
// -----------------------------------------------------------------------------
module mem_ld_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0]    rdata,
    input  logic [1:0]         addr_lo,
    input  logic [LD_OP_W-1:0] ld_op,
    output logic [XLEN-1:0]    result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Selecting rdata[8*addr_lo +: 8] is the low byte of rdata >> (8*addr_lo);
    // halves only use addr_lo[1] since EX guarantees alignment.
    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: result gets a default first so no path through this block can infer a latch.
        result = '0;
        if (ld_op[LD_B])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op[LD_BU])
            result = {24'd0, byte_sel};
        else if (ld_op[LD_H])
            result = {{16{half_sel[15]}}, half_sel};
        else if (ld_op[LD_HU])
            result = {16'd0, half_sel};
        else if (ld_op[LD_W])
            result = rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// MEM stage of the 5-stage LoongArch pipeline. Latches EX results, waits for
// the data-SRAM load response (sram-like data_ok), aligns/extends load data
// and hands {rf_we, dest, result, pc} to WB under a valid/allowin handshake.
// Destination info is also fed back to decode for stall or bypass.
//
// Configuration macro: MS_FWD_EN
//   defined   -> ms_to_ds_bus carries ms_ready_go and final_result (bypass)
//   undefined -> those two fields are driven 0 (decode stalls on dest match)
//
// Ports:
//   clk               in   1   core clock
//   reset             in   1   asynchronous, active-high reset
//   ms_allowin        out  1   MEM can accept from EX this cycle
//   es_to_ms_valid    in   1   EX holds a valid instruction
//   es_to_ms_bus      in   78  {ld_op,mem_ld,rf_we,dest,addr_lo,alu_res,pc}
//   ws_allowin        in   1   WB can accept
//   ms_to_ws_valid    out  1   MEM presents a completed instruction
//   ms_to_ws_bus      out  70  {rf_we,dest,final_result,pc}
//   data_sram_data_ok in   1   load response valid (one pulse per load)
//   data_sram_rdata   in   32  load response data
//   ms_to_ds_bus      out  40  {ms_valid,ms_ready_go,rf_we,dest,result}
// -----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [XLEN-1:0]            data_sram_rdata,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus
);

    es_to_ms_t       es_in;
    es_to_ms_t       ms_r;
    logic            ms_valid;
    ms_state_e       state;
    logic [XLEN-1:0] rdata_buf;

    logic            buf_vld;
    logic            data_ok_q;
    logic            ms_ready_go;
    logic            capture;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] ld_result;
    logic [XLEN-1:0] final_result;

    assign es_in = es_to_ms_bus;

    // A data_ok outside WAIT has no outstanding load to match; drop it.
    assign buf_vld   = (state == S_HOLD);
    assign data_ok_q = data_sram_data_ok & (state == S_WAIT);

    assign ms_ready_go    = !ms_r.mem_ld | data_ok_q | buf_vld;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go;
    assign capture        = es_to_ms_valid & ms_allowin;

    // Once the response has been buffered the live SRAM bus is no longer ours.
    assign load_data = buf_vld ? rdata_buf : data_sram_rdata;

    mem_ld_align u_ld_align (
        .rdata   (load_data),
        .addr_lo (ms_r.addr_lo),
        .ld_op   (ms_r.ld_op),
        .result  (ld_result)
    );

    assign final_result = ms_r.mem_ld ? ld_result : ms_r.alu_res;
    assign ms_to_ws_bus = {ms_r.rf_we, ms_r.dest, final_result, ms_r.pc};

`ifdef MS_FWD_EN
    assign ms_to_ds_bus = {ms_valid, ms_ready_go, ms_r.rf_we, ms_r.dest, final_result};
`else
    assign ms_to_ds_bus = {ms_valid, 1'b0, ms_r.rf_we, ms_r.dest, {XLEN{1'b0}}};
`endif

    // Pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            // NOTE: the payload register is cleared too, not just the valid bit,
            // so the outputs never show X after reset.
            ms_r     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (capture)
                ms_r <= es_in;
        end
    end

    // Load-tracking FSM. A capture always restarts tracking for the incoming
    // instruction, which covers handoff and new-load capture in one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rdata_buf <= '0;
        end else if (capture) begin
            state <= es_in.mem_ld ? S_WAIT : S_IDLE;
        end else begin
            unique case (state)
                S_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (ws_allowin) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_HOLD;
                            rdata_buf <= data_sram_rdata;
                        end
                    end
                end
                S_HOLD: begin
                    if (ws_allowin)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Directed bench for mem_stage: ALU pass-through, byte/half/word loads,
// delayed data_ok, WB back-pressure into HOLD, back-to-back loads and an
// asynchronous reset while a load is outstanding.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [77:0] es_to_ms_bus;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [39:0] ms_to_ds_bus;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [4:0] OP_B  = 5'b10000;
    localparam logic [4:0] OP_H  = 5'b01000;
    localparam logic [4:0] OP_W  = 5'b00100;
    localparam logic [4:0] OP_BU = 5'b00010;
    localparam logic [4:0] OP_HU = 5'b00001;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [77:0] es_bus(input logic [4:0] op, input logic ld,
                                           input logic we, input logic [4:0] d,
                                           input logic [1:0] lo, input logic [31:0] alu,
                                           input logic [31:0] pc);
        return {op, ld, we, d, lo, alu, pc};
    endfunction

    function automatic logic [69:0] ws_bus(input logic we, input logic [4:0] d,
                                           input logic [31:0] res, input logic [31:0] pc);
        return {we, d, res, pc};
    endfunction

    // Expected decode feedback; bypass fields only exist with MS_FWD_EN.
    function automatic logic [39:0] ds_bus(input logic v, input logic rg, input logic we,
                                           input logic [4:0] d, input logic [31:0] res);
`ifdef MS_FWD_EN
        return {v, rg, we, d, res};
`else
        return {v, 1'b0, we, d, 32'd0};
`endif
    endfunction

    task automatic check(input string tag, input logic [77:0] observed, input logic [77:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_allowin", ms_allowin, 1);
        check("rst_ws_valid", ms_to_ws_valid, 0);
        check("rst_ds_bus", ms_to_ds_bus, ds_bus(0, 1, 0, 5'd0, 32'd0));
        reset = 1'b0;

        // ---- ALU op, one cycle in MEM ----
        cyc();
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(5'd0, 0, 1, 5'd4, 2'd0, 32'h1234_5678, 32'h1c00_0000);
        #1 check("alu_allowin_empty", ms_allowin, 1);
        cyc();
        es_to_ms_valid = 1'b0;
        #1;
        check("alu_valid", ms_to_ws_valid, 1);
        check("alu_bus", ms_to_ws_bus, ws_bus(1, 5'd4, 32'h1234_5678, 32'h1c00_0000));
        check("alu_ds_bus", ms_to_ds_bus, ds_bus(1, 1, 1, 5'd4, 32'h1234_5678));
        cyc();
        #1 check("alu_drained", ms_to_ws_valid, 0);

        // ---- ld_b addr_lo=3, data_ok in entry cycle ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_B, 1, 1, 5'd5, 2'd3, 32'h0000_1003, 32'h1c00_0010);
        cyc();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AA_BBCC;
        #1;
        check("ldb_valid", ms_to_ws_valid, 1);
        check("ldb_bus", ms_to_ws_bus, ws_bus(1, 5'd5, 32'hFFFF_FF80, 32'h1c00_0010));
        cyc();
        data_sram_data_ok = 1'b0;

        // ---- ld_bu same data ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_BU, 1, 1, 5'd6, 2'd3, 32'h0000_1003, 32'h1c00_0014);
        cyc();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80AA_BBCC;
        #1;
        check("ldbu_bus", ms_to_ws_bus, ws_bus(1, 5'd6, 32'h0000_0080, 32'h1c00_0014));
        check("ldbu_ds_bus", ms_to_ds_bus, ds_bus(1, 1, 1, 5'd6, 32'h0000_0080));
        cyc();
        data_sram_data_ok = 1'b0;
        #1 check("ldbu_drained", ms_to_ws_valid, 0);

        // ---- ld_hu addr_lo=2, data_ok after 3 waiting cycles ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_HU, 1, 1, 5'd7, 2'd2, 32'h0000_2002, 32'h1c00_0018);
        cyc();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ldhu_wait%0d_valid", i), ms_to_ws_valid, 0);
            check($sformatf("ldhu_wait%0d_allowin", i), ms_allowin, 0);
            cyc();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_7FFF;
        #1;
        check("ldhu_valid", ms_to_ws_valid, 1);
        check("ldhu_bus", ms_to_ws_bus, ws_bus(1, 5'd7, 32'h0000_8001, 32'h1c00_0018));
        cyc();
        data_sram_data_ok = 1'b0;

        // ---- ld_w with WB stalled 2 cycles -> HOLD ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_W, 1, 1, 5'd8, 2'd0, 32'h0000_3000, 32'h1c00_001c);
        cyc();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        check("ldw_stall0_bus", ms_to_ws_bus, ws_bus(1, 5'd8, 32'hDEAD_BEEF, 32'h1c00_001c));
        check("ldw_stall0_allowin", ms_allowin, 0);
        cyc();
        // Stray data_ok in HOLD with different data must be ignored.
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        #1;
        check("ldw_hold_valid", ms_to_ws_valid, 1);
        check("ldw_hold_bus", ms_to_ws_bus, ws_bus(1, 5'd8, 32'hDEAD_BEEF, 32'h1c00_001c));
        cyc();
        data_sram_data_ok = 1'b0;
        ws_allowin        = 1'b1;
        #1;
        check("ldw_release_bus", ms_to_ws_bus, ws_bus(1, 5'd8, 32'hDEAD_BEEF, 32'h1c00_001c));
        check("ldw_release_allowin", ms_allowin, 1);
        cyc();
        #1 check("ldw_drained", ms_to_ws_valid, 0);

        // ---- back-to-back loads, handoff and capture in the same cycle ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_W, 1, 1, 5'd9, 2'd0, 32'h0000_4000, 32'h1c00_0020);
        cyc();
        es_to_ms_bus      = es_bus(OP_H, 1, 1, 5'd0, 2'd0, 32'h0000_4004, 32'h1c00_0024);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0A0A_0A0A;
        #1;
        check("b2b_first_bus", ms_to_ws_bus, ws_bus(1, 5'd9, 32'h0A0A_0A0A, 32'h1c00_0020));
        check("b2b_first_allowin", ms_allowin, 1);
        cyc();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_F234;
        #1;
        check("b2b_second_valid", ms_to_ws_valid, 1);
        check("b2b_second_bus", ms_to_ws_bus, ws_bus(1, 5'd0, 32'hFFFF_F234, 32'h1c00_0024));
        cyc();
        data_sram_data_ok = 1'b0;

        // ---- reset while a load is outstanding ----
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(OP_W, 1, 1, 5'd10, 2'd0, 32'h0000_5000, 32'h1c00_0028);
        cyc();
        es_to_ms_valid = 1'b0;
        #1 check("rwait_allowin", ms_allowin, 0);
        reset = 1'b1;
        #1;
        check("rmid_ws_valid", ms_to_ws_valid, 0);
        check("rmid_allowin", ms_allowin, 1);
        check("rmid_ds_bus", ms_to_ds_bus, ds_bus(0, 1, 0, 5'd0, 32'd0));
        cyc();
        reset = 1'b0;

        // After reset: non-load with rf_we=0 passes straight through.
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = es_bus(5'd0, 0, 0, 5'd11, 2'd1, 32'hCAFE_F00D, 32'h1c00_002c);
        cyc();
        es_to_ms_valid = 1'b0;
        #1 check("post_rst_bus", ms_to_ws_bus, ws_bus(0, 5'd11, 32'hCAFE_F00D, 32'h1c00_002c));
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
